// File: rtl/sequenciador_pkg.sv
// Shared state codes, command field positions and the base-dispatch rule
// used by the move sequencer.
package sequenciador_pkg;

    typedef enum logic [3:0] {
        INICIAL            = 4'h0,
        REGISTRA           = 4'h1,
        PEDE_PETELECO      = 4'h2,
        ESPERA_PETELECO    = 4'h3,
        PEDE_TAMPA_FECHA   = 4'h4,
        ESPERA_TAMPA_FECHA = 4'h5,
        PEDE_BASE          = 4'h6,
        ESPERA_BASE        = 4'h7,
        PEDE_TAMPA_ABRE    = 4'h8,
        ESPERA_TAMPA_ABRE  = 4'h9,
        FIM                = 4'hA,
        ERRO               = 4'hB
    } estado_t;

    localparam int SEGURA_BIT = 4;
    localparam int PET_MSB    = 3;
    localparam int PET_LSB    = 2;
    localparam int BASE_MSB   = 1;
    localparam int BASE_LSB   = 0;

    // Once no flips remain: close the lid first if the cube must be held,
    // otherwise rotate straight away, or finish when there is nothing to turn.
    function automatic estado_t despacho_base(input logic [1:0] cont_base,
                                              input logic       segura);
        if (cont_base != 2'd0 && segura)
            return PEDE_TAMPA_FECHA;
        else if (cont_base != 2'd0)
            return PEDE_BASE;
        else
            return FIM;
    endfunction

endpackage

// File: rtl/contador_timeout.sv
// Per-request watchdog: cleared while a request is issued, counts while
// waiting, and flags when the wait has reached its limit.
module contador_timeout
    import sequenciador_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 100000000,
    parameter int TIMEOUT_W      = 27
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam logic [TIMEOUT_W-1:0] LIMITE = TIMEOUT_W'(TIMEOUT_CICLOS - 1);

    logic [TIMEOUT_W-1:0] contagem;

    // Saturates at the limit so a stalled wait can never wrap back to zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            contagem <= '0;
        else if (zera)
            contagem <= '0;
        else if (conta && !fim)
            contagem <= contagem + TIMEOUT_W'(1);
    end

    assign fim = (contagem == LIMITE);

endmodule

// File: rtl/sequenciador_movimentos.sv
// Expands one cube-move command into single-servo request pulses, waiting
// for the servo manager between requests and guarding each wait.
module sequenciador_movimentos
    import sequenciador_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 100000000,
    parameter int TIMEOUT_W      = 27
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [4:0] movimento,
    input  logic       pronto_servos,
    output logic       move_servo_peteleco,
    output logic       move_servo_tampa,
    output logic       move_servo_base,
    output logic       ocupado,
    output logic       pronto,
    output logic       erro,
    output logic [3:0] db_estado
);

    estado_t    estado;
    estado_t    proximo;
    logic       segura;
    logic [1:0] cont_pet;
    logic [1:0] cont_base;
    logic [1:0] pet_menos1;
    logic [1:0] base_menos1;
    logic       zera_wd;
    logic       conta_wd;
    logic       timeout;

    contador_timeout #(
        .TIMEOUT_CICLOS (TIMEOUT_CICLOS),
        .TIMEOUT_W      (TIMEOUT_W)
    ) u_watchdog (
        .clock (clock),
        .reset (reset),
        .zera  (zera_wd),
        .conta (conta_wd),
        .fim   (timeout)
    );

    assign pet_menos1  = cont_pet - 2'd1;
    assign base_menos1 = cont_base - 2'd1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            estado <= INICIAL;
        else
            estado <= proximo;
    end

    // Command latch and remaining-move counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            segura    <= 1'b0;
            cont_pet  <= 2'd0;
            cont_base <= 2'd0;
        end else begin
            if (estado == INICIAL && iniciar) begin
                segura    <= movimento[SEGURA_BIT];
                cont_pet  <= movimento[PET_MSB:PET_LSB];
                cont_base <= movimento[BASE_MSB:BASE_LSB];
            end
            if (estado == ESPERA_PETELECO && pronto_servos)
                cont_pet <= pet_menos1;
            if (estado == ESPERA_BASE && pronto_servos)
                cont_base <= base_menos1;
        end
    end

    // In every wait state a pronto_servos in the timeout cycle takes priority.
    always_comb begin
        proximo = estado;
        case (estado)
            INICIAL:
                if (iniciar) proximo = REGISTRA;
            REGISTRA:
                proximo = (cont_pet != 2'd0) ? PEDE_PETELECO
                                             : despacho_base(cont_base, segura);
            PEDE_PETELECO:
                proximo = ESPERA_PETELECO;
            ESPERA_PETELECO:
                if (pronto_servos)
                    proximo = (pet_menos1 != 2'd0) ? PEDE_PETELECO
                                                   : despacho_base(cont_base, segura);
                else if (timeout)
                    proximo = ERRO;
            PEDE_TAMPA_FECHA:
                proximo = ESPERA_TAMPA_FECHA;
            ESPERA_TAMPA_FECHA:
                if (pronto_servos)
                    proximo = PEDE_BASE;
                else if (timeout)
                    proximo = ERRO;
            PEDE_BASE:
                proximo = ESPERA_BASE;
            ESPERA_BASE:
                if (pronto_servos) begin
                    if (base_menos1 != 2'd0)
                        proximo = PEDE_BASE;
                    else
                        proximo = segura ? PEDE_TAMPA_ABRE : FIM;
                end else if (timeout) begin
                    proximo = ERRO;
                end
            PEDE_TAMPA_ABRE:
                proximo = ESPERA_TAMPA_ABRE;
            ESPERA_TAMPA_ABRE:
                if (pronto_servos)
                    proximo = FIM;
                else if (timeout)
                    proximo = ERRO;
            FIM:
                proximo = INICIAL;
            ERRO:
                if (iniciar) proximo = INICIAL;
            default:
                proximo = INICIAL;
        endcase
    end

    always_comb begin
        move_servo_peteleco = 1'b0;
        move_servo_tampa    = 1'b0;
        move_servo_base     = 1'b0;
        ocupado             = 1'b1;
        pronto              = 1'b0;
        erro                = 1'b0;
        zera_wd             = 1'b0;
        conta_wd            = 1'b0;
        db_estado           = estado;
        case (estado)
            INICIAL:            ocupado = 1'b0;
            PEDE_PETELECO:      begin move_servo_peteleco = 1'b1; zera_wd = 1'b1; end
            PEDE_TAMPA_FECHA,
            PEDE_TAMPA_ABRE:    begin move_servo_tampa = 1'b1; zera_wd = 1'b1; end
            PEDE_BASE:          begin move_servo_base = 1'b1; zera_wd = 1'b1; end
            ESPERA_PETELECO,
            ESPERA_TAMPA_FECHA,
            ESPERA_BASE,
            ESPERA_TAMPA_ABRE:  conta_wd = 1'b1;
            FIM:                begin ocupado = 1'b0; pronto = 1'b1; end
            ERRO:               begin ocupado = 1'b0; erro = 1'b1; end
            default:            ocupado = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_sequenciador_movimentos.sv
// Bench for the move sequencer: a queue-based model of the expected request
// stream, a servo responder, directed scenarios and a randomized soak.
module tb_sequenciador_movimentos;

    localparam int T = 16;
    localparam int M_IDLE = 0, M_PRE = 1, M_REQ = 2, M_WAIT = 3, M_DONE = 4, M_ERR = 5;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic [4:0] movimento = '0;
    logic       resp_p = 1'b0;
    logic       stray_p = 1'b0;
    logic       pronto_servos;
    logic       move_servo_peteleco, move_servo_tampa, move_servo_base;
    logic       ocupado, pronto, erro;
    logic [3:0] db_estado;
    logic [9:0] saida;

    assign pronto_servos = resp_p | stray_p;
    assign saida = {move_servo_peteleco, move_servo_tampa, move_servo_base,
                    ocupado, pronto, erro, db_estado};

    sequenciador_movimentos #(
        .TIMEOUT_CICLOS (T),
        .TIMEOUT_W      (4)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .iniciar             (iniciar),
        .movimento           (movimento),
        .pronto_servos       (pronto_servos),
        .move_servo_peteleco (move_servo_peteleco),
        .move_servo_tampa    (move_servo_tampa),
        .move_servo_base     (move_servo_base),
        .ocupado             (ocupado),
        .pronto              (pronto),
        .erro                (erro),
        .db_estado           (db_estado)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at cycle %0d", nome, got, exp, cyc);
        end
    endtask

    // Model: the command becomes a queue of request state codes (2 flip,
    // 4 lid close, 6 base turn, 8 lid open); each is served in order.
    int m_mode = M_IDLE;
    int m_wait = 0;
    int m_q[$];

    task automatic carrega(input logic [4:0] m);
        int np = int'(m[3:2]);
        int nb = int'(m[1:0]);
        m_q.delete();
        repeat (np) m_q.push_back(2);
        if (nb > 0) begin
            if (m[4]) m_q.push_back(4);
            repeat (nb) m_q.push_back(6);
            if (m[4]) m_q.push_back(8);
        end
    endtask

    initial forever begin
        @(posedge clock or negedge reset);
        if (!reset) begin
            m_mode = M_IDLE;
            m_q.delete();
        end else begin
            case (m_mode)
                M_IDLE: if (iniciar) begin carrega(movimento); m_mode = M_PRE; end
                M_PRE:  m_mode = (m_q.size() == 0) ? M_DONE : M_REQ;
                M_REQ:  begin m_mode = M_WAIT; m_wait = 1; end
                M_WAIT: begin
                    if (pronto_servos) begin
                        void'(m_q.pop_front());
                        m_mode = (m_q.size() == 0) ? M_DONE : M_REQ;
                    end else if (m_wait == T) begin
                        m_mode = M_ERR;
                    end else begin
                        m_wait++;
                    end
                end
                M_DONE: m_mode = M_IDLE;
                M_ERR:  if (iniciar) m_mode = M_IDLE;
                default: m_mode = M_IDLE;
            endcase
        end
    end

    function automatic logic [9:0] esperado();
        int h = (m_q.size() > 0) ? m_q[0] : 0;
        case (m_mode)
            M_PRE:   return {3'b000, 3'b100, 4'h1};
            M_REQ:   return {h == 2, (h == 4) || (h == 8), h == 6, 3'b100, 4'(h)};
            M_WAIT:  return {3'b000, 3'b100, 4'(h + 1)};
            M_DONE:  return {3'b000, 3'b010, 4'hA};
            M_ERR:   return {3'b000, 3'b001, 4'hB};
            default: return 10'h000;
        endcase
    endfunction

    bit cmp_en = 1'b0;
    initial forever begin
        @(negedge clock);
        if (cmp_en && reset) chk("cycle", 32'(saida), 32'(esperado()));
    end

    // Request log and pronto_servos cycle log.
    int req_kind[$];
    int req_cyc[$];
    int ps_cyc[$];

    initial forever begin
        @(posedge clock);
        if (reset && pronto_servos) ps_cyc.push_back(cyc);
        cyc++;
    end

    initial forever begin
        @(negedge clock);
        if (move_servo_peteleco) begin req_kind.push_back(1); req_cyc.push_back(cyc); end
        if (move_servo_tampa)    begin req_kind.push_back(2); req_cyc.push_back(cyc); end
        if (move_servo_base)     begin req_kind.push_back(3); req_cyc.push_back(cyc); end
    end

    // Servo responder: pronto_servos `delay` cycles after each request.
    int delay = 3;
    int cnt = 0;
    bit silent = 1'b0;
    bit rand_delay = 1'b0;

    initial forever begin
        @(negedge clock);
        resp_p = 1'b0;
        if (!reset) begin
            cnt = 0;
        end else begin
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) resp_p = 1'b1;
            end
            if ((move_servo_peteleco || move_servo_tampa || move_servo_base) && !silent) begin
                if (rand_delay) begin
                    int r = int'($urandom_range(0, 9));
                    cnt = (r == 8) ? 16 : (r == 9) ? 17 : r + 1;
                end else begin
                    cnt = delay;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic start(input logic [4:0] m);
        movimento = m;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
    endtask

    task automatic limpa_logs();
        req_kind.delete();
        req_cyc.delete();
        ps_cyc.delete();
    endtask

    // Returns ok=1 at the negedge showing pronto; ok=0 on erro or expiry.
    task automatic wait_fim(output int c, output bit ok);
        ok = 1'b0;
        c = -1;
        for (int i = 0; i < 400; i++) begin
            if (pronto) begin ok = 1'b1; c = cyc; return; end
            if (erro) return;
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1, "simulation bound exceeded");
    end

    initial begin
        int  t0, c, ec, n, np;
        bit  ok;
        int  ek[6] = '{1, 2, 3, 3, 3, 2};

        repeat (3) tick();
        chk("reset_saidas", 32'(saida), 32'h0);
        reset = 1'b1;
        cmp_en = 1'b1;
        tick();
        chk("pos_reset_db", 32'(db_estado), 32'h0);

        // Empty command: pronto two cycles after iniciar, no requests.
        limpa_logs();
        t0 = cyc;
        start(5'b00000);
        chk("t1_ocupado_c1", 32'(ocupado), 32'h1);
        chk("t1_db_c1", 32'(db_estado), 32'h1);
        tick();
        chk("t1_pronto_c2", 32'(pronto), 32'h1);
        chk("t1_ocupado_c2", 32'(ocupado), 32'h0);
        chk("t1_cyc_pronto", 32'(cyc - t0), 32'd2);
        tick();
        chk("t1_volta_inicial", 32'(db_estado), 32'h0);
        chk("t1_sem_pedidos", 32'(req_kind.size()), 32'd0);

        // Two flips only.
        limpa_logs();
        start(5'b01000);
        wait_fim(c, ok);
        chk("t2_concluiu", 32'(ok), 32'h1);
        chk("t2_n_pedidos", 32'(req_kind.size()), 32'd2);
        foreach (req_kind[i]) chk("t2_tipo", 32'(req_kind[i]), 32'd1);
        chk("t2_pronto_apos_ps", 32'(c), 32'((ps_cyc.size() > 0) ? ps_cyc[$] + 1 : -1));
        tick();

        // Held cube: flip, close, three turns, open.
        limpa_logs();
        t0 = cyc;
        start(5'b10111);
        wait_fim(c, ok);
        chk("t3_concluiu", 32'(ok), 32'h1);
        chk("t3_n_pedidos", 32'(req_kind.size()), 32'd6);
        for (int i = 0; i < 6 && i < req_kind.size(); i++) begin
            chk("t3_ordem", 32'(req_kind[i]), 32'(ek[i]));
            chk("t3_cyc_pedido", 32'(req_cyc[i] - t0), 32'(2 + 4 * i));
            if (i > 0 && i - 1 < ps_cyc.size())
                chk("t3_apos_ps", 32'(req_cyc[i]), 32'(ps_cyc[i - 1] + 1));
        end
        chk("t3_cyc_pronto", 32'(c - t0), 32'd26);
        tick();

        // Silent servo: timeout, clearing iniciar, then a normal run.
        limpa_logs();
        silent = 1'b1;
        t0 = cyc;
        ec = -1;
        start(5'b00001);
        for (int i = 0; i < 100; i++) begin
            if (erro) begin ec = cyc; break; end
            tick();
        end
        chk("t4_cyc_erro", 32'(ec - t0), 32'd19);
        chk("t4_ocupado", 32'(ocupado), 32'h0);
        chk("t4_db_erro", 32'(db_estado), 32'hB);
        repeat (3) tick();
        chk("t4_erro_mantido", 32'(erro), 32'h1);
        start(5'b01011);
        chk("t4_limpa_db", 32'(db_estado), 32'h0);
        chk("t4_limpa_erro", 32'(erro), 32'h0);
        repeat (4) tick();
        chk("t4_sem_novo_pedido", 32'(req_kind.size()), 32'd1);
        chk("t4_parado", 32'(db_estado), 32'h0);
        silent = 1'b0;
        start(5'b00001);
        wait_fim(c, ok);
        chk("t4_reinicio", 32'(ok), 32'h1);
        chk("t4_n_pedidos", 32'(req_kind.size()), 32'd2);
        tick();

        // Response in the very cycle of the timeout wins; one later loses.
        delay = 16;
        start(5'b00001);
        wait_fim(c, ok);
        chk("t4b_limite_ganha", 32'(ok), 32'h1);
        tick();
        delay = 17;
        start(5'b00001);
        wait_fim(c, ok);
        chk("t4b_limite_perde", 32'(erro), 32'h1);
        repeat (2) tick();
        start(5'b00000);
        tick();
        delay = 3;

        // Stray pronto_servos while idle, iniciar noise while turning.
        stray_p = 1'b1;
        tick();
        stray_p = 1'b0;
        chk("t5_stray_db", 32'(db_estado), 32'h0);
        chk("t5_stray_ocupado", 32'(ocupado), 32'h0);
        limpa_logs();
        movimento = 5'b00011;
        iniciar = 1'b1;
        tick();
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (pronto) begin ok = 1'b1; break; end
            iniciar = (db_estado == 4'h7);
            tick();
        end
        iniciar = 1'b0;
        chk("t5_concluiu", 32'(ok), 32'h1);
        chk("t5_n_bases", 32'(req_kind.size()), 32'd3);
        foreach (req_kind[i]) chk("t5_tipo", 32'(req_kind[i]), 32'd3);
        tick();
        chk("t5_sem_reinicio", 32'(db_estado), 32'h0);

        // Reset while waiting for the lid to close.
        limpa_logs();
        start(5'b10001);
        for (int i = 0; i < 50 && db_estado != 4'h5; i++) tick();
        chk("t6_chegou_tampa", 32'(db_estado), 32'h5);
        @(posedge clock);
        #2 reset = 1'b0;
        #1 chk("t6_reset_imediato", 32'(saida), 32'h0);
        tick();
        tick();
        reset = 1'b1;
        chk("t6_db_pos_reset", 32'(db_estado), 32'h0);
        tick();
        limpa_logs();
        start(5'b00001);
        wait_fim(c, ok);
        chk("t6_novo_comando", 32'(ok), 32'h1);
        chk("t6_n_pedidos", 32'(req_kind.size()), 32'd1);
        if (req_kind.size() > 0) chk("t6_tipo", 32'(req_kind[0]), 32'd3);
        tick();

        // Randomized soak: command, iniciar, stray pulses and servo latency
        // all vary; the per-cycle compare does the checking.
        rand_delay = 1'b1;
        n = 0;
        np = 0;
        for (int i = 0; i < 3000; i++) begin
            iniciar   = ($urandom_range(0, 5) == 0);
            movimento = 5'($urandom);
            stray_p   = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 300) == 0) silent = ($urandom_range(0, 3) == 0);
            if (pronto) np++;
            if (move_servo_peteleco || move_servo_tampa || move_servo_base) n++;
            tick();
        end
        iniciar = 1'b0;
        stray_p = 1'b0;
        silent  = 1'b0;
        repeat (40) tick();
        chk("rand_houve_pronto", 32'(np > 0), 32'h1);
        chk("rand_houve_pedidos", 32'(n > 0), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sequenciador_movimentos.md
Name: sequenciador_movimentos

Overview:
- Upstream neighbour of the servo manager FSM.
- Takes one cube-move command and expands it into an ordered series of single-servo requests (flip arm "peteleco", lid "tampa", base rotation "base").
- Issues each request as a 1-cycle pulse and waits for the servo manager's `pronto` pulse before issuing the next.
- Adds a per-request watchdog and reports completion or timeout to the solver-level control.

Parameters:
- TIMEOUT_CICLOS, 100000000, max cycles to wait for `pronto_servos` after a request (2 s at 50 MHz).
- TIMEOUT_W, 27, watchdog counter width; must hold TIMEOUT_CICLOS-1.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset; low forces all state and outputs to reset values immediately.
- iniciar  in  1  start strobe; sampled only in state inicial (and erro, see below).
- movimento  in  5  command {segura[4], n_peteleco[3:2], n_base[1:0]}; latched when iniciar is accepted.
- pronto_servos  in  1  1-cycle completion pulse from the servo manager.
- move_servo_peteleco  out  1  1-cycle request pulse to the servo manager.
- move_servo_tampa  out  1  1-cycle request pulse to the servo manager.
- move_servo_base  out  1  1-cycle request pulse to the servo manager.
- ocupado  out  1  high in every state except inicial, fim and erro.
- pronto  out  1  1-cycle pulse in state fim.
- erro  out  1  high while in state erro.
- db_estado  out  4  current state code, for debug.

Behaviour:
- Reset (reset=0): state inicial; all outputs 0; db_estado=0000; latched command and counters cleared.
- State codes: inicial 0, registra 1, pede_peteleco 2, espera_peteleco 3, pede_tampa_fecha 4, espera_tampa_fecha 5, pede_base 6, espera_base 7, pede_tampa_abre 8, espera_tampa_abre 9, fim A, erro B. Unused codes go to inicial.
- Outputs are Moore (decoded from the state register).
  - move_servo_peteleco=1 only in pede_peteleco.
  - move_servo_tampa=1 in pede_tampa_fecha and in pede_tampa_abre.
  - move_servo_base=1 only in pede_base.
  - At most one request is high in any cycle.
- Each pede_* state lasts exactly 1 cycle, then moves to the matching espera_*.
- inicial:
  - iniciar=1: latch segura, cont_pet=n_peteleco, cont_base=n_base; go to registra.
  - Otherwise stay.
- registra and "after flips" dispatch (shared decision):
  - cont_pet>0: go to pede_peteleco.
  - else cont_base>0 and segura=1: go to pede_tampa_fecha.
  - else cont_base>0: go to pede_base.
  - else: go to fim.
- espera_peteleco with pronto_servos: cont_pet decrements; if the new value is >0, go to pede_peteleco; else apply the base dispatch above.
- espera_tampa_fecha with pronto_servos: go to pede_base.
- espera_base with pronto_servos: cont_base decrements; if >0, go to pede_base; else segura=1 goes to pede_tampa_abre, segura=0 goes to fim.
- espera_tampa_abre with pronto_servos: go to fim.
- fim: pronto=1 for 1 cycle, then go to inicial.
- Watchdog:
  - Cleared in every pede_* state; increments each cycle in espera_*.
  - Reaching TIMEOUT_CICLOS-1 without pronto_servos goes to erro.
  - If pronto_servos arrives in the same cycle as the timeout, pronto_servos wins.
- erro: erro=1 until iniciar=1, which returns to inicial; that iniciar does not start a command.
- Ignored inputs:
  - iniciar in any other state (busy).
  - pronto_servos outside espera_* states (stray pulse).
  - movimento changes after latching.
- Latency:
  - iniciar at cycle 0 gives registra at cycle 1 and the first request at cycle 2.
  - Command 00000 gives pronto at cycle 2.
  - The next request follows pronto_servos by 1 cycle (pede_* state). The servo manager is back in its initial state by then.

Decomposition:
- Package `sequenciador_pkg`:
  - state code constants;
  - command field positions (SEGURA_BIT=4, PET_MSB/LSB=3/2, BASE_MSB/LSB=1/0).
- Sub-module `contador_timeout`:
  - ports: clock, reset, zera, conta, fim;
  - parameterised by TIMEOUT_CICLOS and TIMEOUT_W;
  - instantiated once.
- Everything else (FSM, down-counters) lives in the top module.

Test Plan:
- Bench setup: TIMEOUT_CICLOS=16; responder model returns pronto_servos 3 cycles after each request.
- movimento=00000, iniciar at cycle 0 -> pronto=1 at cycle 2, no request pulses, ocupado=1 only at cycle 1.
- movimento=0_10_00 -> exactly 2 move_servo_peteleco pulses and no tampa/base pulses; pronto 1 cycle after the fim transition.
- movimento=1_01_11 -> pulse order: peteleco, tampa, base, base, base, tampa; each request exactly 1 cycle wide and exactly 1 cycle after the preceding pronto_servos; then pronto.
- movimento=0_00_01, responder silent -> erro=1 when the watchdog reaches 15; ocupado=0; second iniciar returns to inicial with no request; third iniciar starts normally.
- Stray pronto_servos in inicial plus iniciar pulses during espera_base -> no state change or extra requests; the sequence count is unchanged.
- reset low during espera_tampa_fecha -> all outputs 0 immediately; db_estado=0000; after release, a new command runs from the start with no leftover counts.
